// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types and helpers for the UART receive path (and the future
//   transmit path).
//   Contents:
//     UART_DATA_W      payload width of one UART character
//     uart_rx_state_e  receiver FSM states
//     cps()            clock cycles per symbol for a given clock / line rate
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_e;

    function automatic int cps(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with a registered storage array. The head entry is
//   always presented on data_o while valid_o is high, and it does not change
//   until it is popped.
//   Parameters:
//     WIDTH   entry width
//     DEPTH   number of entries (power of two, >= 2)
//   Ports:
//     clk_i     in   clock, posedge
//     rst_ni    in   asynchronous active-low reset
//     push_i    in   write data_i (accepted when not full, or full with a pop)
//     data_i    in   write data
//     pop_i     in   remove head (ignored when empty)
//     data_o    out  head entry
//     valid_o   out  FIFO not empty
//     full_o    out  FIFO full
//     count_o   out  occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_doPop;
    logic w_doPush;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_doPop  = pop_i & ~w_empty;
    // When full, a same-cycle pop frees the slot the write pointer now points at.
    assign w_doPush = push_i & (~w_full | w_doPop);

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= data_i;
                r_wrPtr        <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_o  = r_mem[r_rdPtr];
    assign valid_o = ~w_empty;
    assign full_o  = w_full;
    assign count_o = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   UART receiver: 2-flop synchronizer, mid-bit sampling FSM for 8N1 frames
//   (8E1 when UART_RX_PARITY_EN is defined), a small FIFO and a valid/ready
//   output stream. Sticky framing and overflow flags.
//   Parameters:
//     FREQ    clock frequency in Hz
//     BAUD    line rate; FREQ/BAUD (cycles per symbol) must be >= 4
//     DEPTH   FIFO entries, power of two, >= 2
//   Ports:
//     clk_i        in   clock, posedge
//     rst_ni       in   asynchronous active-low reset
//     rx_i         in   serial line, idle high, asynchronous
//     rx_valid_o   out  FIFO head valid
//     rx_data_o    out  FIFO head byte
//     rx_ready_i   in   pop head when rx_valid_o & rx_ready_i
//     count_o      out  FIFO occupancy
//     frame_err_o  out  sticky: bad stop bit (or bad parity)
//     overflow_o   out  sticky: byte completed while FIFO full
//     err_clr_i    in   clears both sticky flags; a same-cycle set wins
//   Build option:
//     UART_RX_PARITY_EN  adds an even-parity bit between data and stop.
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FREQ  = 50_000_000,
    parameter int BAUD  = 115_200,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     rx_i,
    output logic                     rx_valid_o,
    output logic [UART_DATA_W-1:0]   rx_data_o,
    input  logic                     rx_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     frame_err_o,
    output logic                     overflow_o,
    input  logic                     err_clr_i
);

    localparam int CPS   = cps(FREQ, BAUD);
    localparam int CYC_W = (CPS > 1) ? $clog2(CPS) : 1;
    localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(CPS / 2 - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CPS - 1);

    if (CPS < 4) begin : g_bad_cps
        $error("uart_rx_fifo: FREQ/BAUD must be at least 4 cycles per symbol");
    end

    logic                   r_rxMeta;
    logic                   r_rxS;
    logic                   r_rxPrev;

    uart_rx_state_e         r_state;
    uart_rx_state_e         w_stateNext;
    logic [CYC_W-1:0]       r_cyc;
    logic [CYC_W-1:0]       w_cycNext;
    logic [2:0]             r_bitIdx;
    logic [2:0]             w_bitIdxNext;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] w_shiftNext;
`ifdef UART_RX_PARITY_EN
    logic                   r_parityErr;
    logic                   w_parityErrNext;
`endif

    logic                   w_push;
    logic                   w_frameSet;
    logic                   w_overflowSet;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_valid;

    logic                   r_frameErr;
    logic                   r_overflow;

    // r_rxPrev holds the previous synchronized sample so IDLE reacts only to a
    // genuine 1->0 edge; a line held low after a bad frame never restarts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rxMeta <= 1'b1;
            r_rxS    <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_rxMeta <= rx_i;
            r_rxS    <= r_rxMeta;
            r_rxPrev <= r_rxS;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_cyc       <= '0;
            r_bitIdx    <= '0;
            r_shift     <= '0;
`ifdef UART_RX_PARITY_EN
            r_parityErr <= 1'b0;
`endif
        end else begin
            r_state     <= w_stateNext;
            r_cyc       <= w_cycNext;
            r_bitIdx    <= w_bitIdxNext;
            r_shift     <= w_shiftNext;
`ifdef UART_RX_PARITY_EN
            r_parityErr <= w_parityErrNext;
`endif
        end
    end

    // The cycle counter restarts at every sample point, so it never wraps
    // inside a state; START samples half a symbol in to land mid-bit.
    always_comb begin
        w_stateNext     = r_state;
        w_cycNext       = r_cyc + CYC_W'(1);
        w_bitIdxNext    = r_bitIdx;
        w_shiftNext     = r_shift;
`ifdef UART_RX_PARITY_EN
        w_parityErrNext = r_parityErr;
`endif
        w_push          = 1'b0;
        w_frameSet      = 1'b0;

        case (r_state)
            IDLE: begin
                w_cycNext = '0;
                if (!r_rxS && r_rxPrev) begin
                    w_stateNext = START;
                end
            end
            START: begin
                if (r_cyc == CYC_HALF) begin
                    w_cycNext = '0;
                    if (r_rxS) begin
                        w_stateNext = IDLE;
                    end else begin
                        w_stateNext  = DATA;
                        w_bitIdxNext = '0;
                    end
                end
            end
            DATA: begin
                if (r_cyc == CYC_LAST) begin
                    w_cycNext    = '0;
                    w_shiftNext  = {r_rxS, r_shift[UART_DATA_W-1:1]};
                    w_bitIdxNext = r_bitIdx + 3'd1;
                    if (r_bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_stateNext = PARITY;
`else
                        w_stateNext = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_cyc == CYC_LAST) begin
                    w_cycNext       = '0;
                    w_parityErrNext = (r_rxS != ^r_shift);
                    w_stateNext     = STOP;
                end
            end
`endif
            STOP: begin
                if (r_cyc == CYC_LAST) begin
                    w_cycNext   = '0;
                    w_stateNext = IDLE;
`ifdef UART_RX_PARITY_EN
                    if (r_rxS && !r_parityErr) begin
`else
                    if (r_rxS) begin
`endif
                        w_push = 1'b1;
                    end else begin
                        w_frameSet = 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cycNext   = '0;
            end
        endcase
    end

    assign w_pop         = rx_ready_i & w_valid;
    assign w_overflowSet = w_push & w_full & ~w_pop;

    // Set has priority over clear so an error in the clearing cycle survives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frameErr <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_frameSet) begin
                r_frameErr <= 1'b1;
            end else if (err_clr_i) begin
                r_frameErr <= 1'b0;
            end
            if (w_overflowSet) begin
                r_overflow <= 1'b1;
            end else if (err_clr_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (r_shift),
        .pop_i   (rx_ready_i),
        .data_o  (rx_data_o),
        .valid_o (w_valid),
        .full_o  (w_full),
        .count_o (count_o)
    );

    assign rx_valid_o  = w_valid;
    assign frame_err_o = r_frameErr;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Drives serial frames into uart_rx_fifo (16 MHz clock, 1 Mbaud, 16 cycles
//   per symbol). Every byte that should reach the consumer is queued when its
//   frame is sent; an independent monitor pops the queue on each accepted
//   output handshake. Flags and occupancy are checked at directed points.
//   Define UART_RX_PARITY_EN to exercise the 8E1 build.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int FREQ  = 16_000_000;
    localparam int BAUD  = 1_000_000;
    localparam int DEPTH = 8;
    localparam int CPS   = FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 10;
`else
    localparam int FRAME_BITS = 9;
`endif
    // Posedges from the start-bit drive edge to the edge that acts on the stop
    // sample: 2 synchronizer flops, 1 edge detect, half a symbol, then the
    // data (+parity) and stop symbols.
    localparam int STOP_EDGE = 3 + CPS / 2 + CPS * FRAME_BITS;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   rx_i;
    logic                   rx_valid_o;
    logic [7:0]             rx_data_o;
    logic                   rx_ready_i;
    logic [$clog2(DEPTH):0] count_o;
    logic                   frame_err_o;
    logic                   overflow_o;
    logic                   err_clr_i;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] expQ[$];
    logic [7:0] monExp;

    uart_rx_fifo #(
        .FREQ  (FREQ),
        .BAUD  (BAUD),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_i        (rx_i),
        .rx_valid_o  (rx_valid_o),
        .rx_data_o   (rx_data_o),
        .rx_ready_i  (rx_ready_i),
        .count_o     (count_o),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .err_clr_i   (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard monitor: one comparison per accepted handshake.
    always @(negedge clk_i) begin
        if (rst_ni && rx_valid_o && rx_ready_i) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL pop: got 0x%02h, required no byte (nothing expected)", rx_data_o);
            end else begin
                monExp = expQ.pop_front();
                if (rx_data_o !== monExp) begin
                    miscompares++;
                    $display("[TB] FAIL pop: got 0x%02h, required 0x%02h", rx_data_o, monExp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Sends one frame; rx_i changes 1 time unit after a posedge.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input logic badParity, input bit expectPush);
        if (expectPush) expQ.push_back(data);
        @(posedge clk_i);
        #1 rx_i = 1'b0;
        repeat (CPS) @(posedge clk_i);
        for (int b = 0; b < 8; b++) begin
            #1 rx_i = data[b];
            repeat (CPS) @(posedge clk_i);
        end
`ifdef UART_RX_PARITY_EN
        #1 rx_i = (^data) ^ badParity;
        repeat (CPS) @(posedge clk_i);
`else
        if (badParity) $display("[TB] note: parity request ignored in 8N1 build");
`endif
        #1 rx_i = stopBit;
        repeat (CPS) @(posedge clk_i);
        #1 rx_i = 1'b1;
    endtask

    task automatic waitDrain(input int maxCycles);
        for (int i = 0; i < maxCycles && expQ.size() != 0; i++) begin
            @(posedge clk_i);
        end
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("drain_left", expQ.size(), 0);
    endtask

    task automatic pulseClear();
        @(posedge clk_i);
        #1 err_clr_i = 1'b1;
        @(posedge clk_i);
        #1 err_clr_i = 1'b0;
    endtask

    initial begin
        rst_ni     = 1'b0;
        rx_i       = 1'b1;
        rx_ready_i = 1'b0;
        err_clr_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_valid", rx_valid_o, 0);
        checkOutput("rst_data", rx_data_o, 0);
        checkOutput("rst_count", count_o, 0);
        checkOutput("rst_frame", frame_err_o, 0);
        checkOutput("rst_ovf", overflow_o, 0);
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);

        // Two back-to-back good frames
        #1 rx_ready_i = 1'b1;
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'hA3, 1'b1, 1'b0, 1'b1);
        waitDrain(50);
        checkOutput("b2b_frame", frame_err_o, 0);
        checkOutput("b2b_ovf", overflow_o, 0);

        // Short low glitch on an idle line
        @(posedge clk_i);
        #1 rx_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1 rx_i = 1'b1;
        repeat (40) @(posedge clk_i);
        #1;
        checkOutput("glitch_count", count_o, 0);
        checkOutput("glitch_frame", frame_err_o, 0);
        checkOutput("glitch_ovf", overflow_o, 0);

        // Bad stop bit, clear, then a good frame
        applyStimulus(8'h7E, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        checkOutput("stop0_frame", frame_err_o, 1);
        checkOutput("stop0_count", count_o, 0);
        pulseClear();
        #1;
        checkOutput("clr_frame", frame_err_o, 0);
        applyStimulus(8'h12, 1'b1, 1'b0, 1'b1);
        waitDrain(50);

        // Overflow: nine bytes into eight slots
        rx_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'(i), 1'b1, 1'b0, (i < 8));
        end
        repeat (4) @(posedge clk_i);
        #1;
        checkOutput("ovf_count", count_o, 8);
        checkOutput("ovf_flag", overflow_o, 1);
        rx_ready_i = 1'b1;
        waitDrain(50);
        checkOutput("ovf_drained", count_o, 0);
        checkOutput("ovf_sticky", overflow_o, 1);
        pulseClear();
        #1;
        checkOutput("ovf_clr", overflow_o, 0);

        // Full FIFO, 9th byte completes in the same cycle as a pop
        rx_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'h10 + 8'(i), 1'b1, 1'b0, 1'b1);
        end
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("full_count", count_o, 8);
        fork
            applyStimulus(8'h18, 1'b1, 1'b0, 1'b1);
            begin
                @(posedge clk_i);
                repeat (STOP_EDGE - 1) @(posedge clk_i);
                #1 rx_ready_i = 1'b1;
                @(posedge clk_i);
                #1 rx_ready_i = 1'b0;
            end
        join
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("pushpop_count", count_o, 8);
        checkOutput("pushpop_ovf", overflow_o, 0);
        rx_ready_i = 1'b1;
        waitDrain(50);
        checkOutput("pushpop_drained", count_o, 0);

        // Leave a byte and a frame error pending, then reset mid-frame
        rx_ready_i = 1'b0;
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("pre_rst_count", count_o, 1);
        checkOutput("pre_rst_frame", frame_err_o, 1);
        fork
            applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
            begin
                @(posedge clk_i);
                repeat (3 + CPS / 2 + CPS * 4 + 4) @(posedge clk_i);
                #1 rst_ni = 1'b0;
                #2;
                checkOutput("mid_rst_valid", rx_valid_o, 0);
                checkOutput("mid_rst_data", rx_data_o, 0);
                checkOutput("mid_rst_count", count_o, 0);
                checkOutput("mid_rst_frame", frame_err_o, 0);
                repeat (3) @(posedge clk_i);
                #1 rst_ni = 1'b1;
            end
        join
        #1 rx_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1);
        waitDrain(50);
        checkOutput("post_rst_frame", frame_err_o, 0);
        checkOutput("post_rst_count", count_o, 0);

`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        checkOutput("parity_frame", frame_err_o, 1);
        checkOutput("parity_count", count_o, 0);
`endif

        repeat (4) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
